// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the BRAM.
// slave = arbiter side; master = requester/memory side (used by the bench).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 12
);
    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;

    logic              d_req;
    logic [3:0]        d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;

    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port BRAM arbiter: load/store (D) has priority over fetch (I), with a
// streak counter that forces one fetch through after MAX_D_STREAK back-to-back D wins.
//
// Handshake: a requester holds req/addr/we/wdata stable until it sees gnt=1 in the
// same cycle; gnt is combinational and the request is consumed on that clock edge.
// Read data returns with rvalid=1 for exactly one cycle, the cycle after the grant.
module mem_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus,
    output logic [3:0]          streak_o,
    output logic [1:0]          owner_o
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    logic [3:0]  streak_q, streak_d;
    owner_e      owner_q, owner_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        i_win;
    logic        d_win;
    logic        i_rvalid;
    logic        d_rvalid;
    logic        unused_addr_bits;

    // Grants are forced low during reset so nothing reaches the BRAM.
    always_comb begin
        i_win = 1'b0;
        d_win = 1'b0;
        if (!reset) begin
            if (bus.d_req && !(bus.i_req && (streak_q == STREAK_MAX))) begin
                d_win = 1'b1;
            end else if (bus.i_req) begin
                i_win = 1'b1;
            end
        end
    end

    always_comb begin
        streak_d = 4'd0;
        if (d_win && bus.i_req) begin
            streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (i_win) begin
            owner_d = OWN_I;
        end else if (d_win && (bus.d_we == 4'b0000)) begin
            owner_d = OWN_D;
        end
    end

    // A read tagged just before reset must not surface while reset is high.
    assign i_rvalid = !reset && (owner_q == OWN_I);
    assign d_rvalid = !reset && (owner_q == OWN_D);

    assign i_rdata_d = i_rvalid ? bus.mem_rdata : i_rdata_q;
    assign d_rdata_d = d_rvalid ? bus.mem_rdata : d_rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q  <= 4'd0;
            owner_q   <= OWN_NONE;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
        end else begin
            streak_q  <= streak_d;
            owner_q   <= owner_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign bus.i_gnt     = i_win;
    assign bus.d_gnt     = d_win;
    assign bus.mem_en    = i_win | d_win;
    assign bus.mem_we    = d_win ? bus.d_we : 4'b0000;
    assign bus.mem_addr  = d_win ? bus.d_addr[ADDR_W+1:2] : bus.i_addr[ADDR_W+1:2];
    assign bus.mem_wdata = bus.d_wdata;

    // The rdata outputs show fresh data in the rvalid cycle and the held copy after.
    assign bus.i_rvalid  = i_rvalid;
    assign bus.d_rvalid  = d_rvalid;
    assign bus.i_rdata   = i_rdata_d;
    assign bus.d_rdata   = d_rdata_d;

    assign streak_o = streak_q;
    assign owner_o  = owner_q;

    assign unused_addr_bits = ^{bus.i_addr[31:ADDR_W+2], bus.i_addr[1:0],
                                bus.d_addr[31:ADDR_W+2], bus.d_addr[1:0]};

    a_one_grant: assert property (@(posedge clk) !(bus.i_gnt && bus.d_gnt));
    a_no_grant_in_reset: assert property (@(posedge clk) reset |-> !bus.mem_en);
    a_streak_bound: assert property (@(posedge clk) disable iff (reset)
                                     streak_q <= STREAK_MAX);

endmodule
